// File: rtl/store_pkg.sv
// Shared definitions for the store merge buffer.
//   st_op_e        : store opcode (none / byte / half / word / double)
//   drain_state_e  : drain FSM state encoding
//   OP_W, BYTE_W   : entry field widths common to every instance
//   off_bits()     : number of byte-offset bits inside one memory word
//   word_bits()    : width of the word address kept in each FIFO entry
package store_pkg;

    typedef enum logic [2:0] {
        ST_NONE = 3'd0,
        ST_B    = 3'd1,
        ST_H    = 3'd2,
        ST_W    = 3'd3,
        ST_D    = 3'd4
    } st_op_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_e;

    localparam int OP_W   = 3;
    localparam int BYTE_W = 8;

    function automatic int off_bits(input int data_w);
        return $clog2(data_w / BYTE_W);
    endfunction

    function automatic int word_bits(input int addr_w, input int data_w);
        return addr_w - $clog2(data_w / BYTE_W);
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane alignment for one store request.
// Ports:
//   op       in   OP_W      store opcode (st_op_e)
//   addr     in   ADDR_W    byte address
//   data     in   DATA_W    register data, LSB-justified
//   byteen   out  DATA_W/8  byte enables, one per lane
//   wdata    out  DATA_W    data shifted into its lanes, unused lanes zero
//   misalign out  1         address not aligned for op (or op not legal here)
module store_lane_align
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic [OP_W-1:0]     op,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data,
    output logic [DATA_W/8-1:0] byteen,
    output logic [DATA_W-1:0]   wdata,
    output logic                misalign
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = off_bits(DATA_W);

    logic [OFF_W-1:0] lane;
    logic [OFF_W+2:0] bit_shift;
    logic             unused_addr_hi;

    assign lane           = addr[OFF_W-1:0];
    assign bit_shift      = {lane, 3'b000};
    assign unused_addr_hi = ^addr[ADDR_W-1:3];

    always_comb begin
        byteen   = '0;
        wdata    = '0;
        misalign = 1'b0;
        case (st_op_e'(op))
            ST_NONE: begin
            end
            ST_B: begin
                byteen = BYTES'(1) << lane;
                wdata  = DATA_W'(data[7:0]) << bit_shift;
            end
            ST_H: begin
                misalign = addr[0];
                byteen   = BYTES'(2'b11) << lane;
                wdata    = DATA_W'(data[15:0]) << bit_shift;
            end
            ST_W: begin
                misalign = (addr[1:0] != 2'b00);
                byteen   = BYTES'(4'hF) << lane;
                wdata    = DATA_W'(data[31:0]) << bit_shift;
            end
            ST_D: begin
                // A doubleword cannot fit a 32-bit memory word at all.
                if (DATA_W == 64) begin
                    misalign = (addr[2:0] != 3'b000);
                    byteen   = '1;
                    wdata    = data;
                end else begin
                    misalign = 1'b1;
                end
            end
            // Undefined opcodes are rejected the same way as misaligned ones
            // so they can never reach memory.
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_merge_buffer.sv
// Store buffer between the M stage and data memory: aligns stores into lanes,
// queues them in a DEPTH-entry FIFO, merges same-word stores into the tail
// entry, drains the head over a req/ack handshake and flags load hazards.
// Ports:
//   clk, reset                    clock / synchronous active-high reset
//   st_valid, st_ready            store request handshake
//   st_op, st_addr, st_data       store opcode, byte address, LSB-justified data
//   st_misalign                   st_valid & address misaligned for st_op
//   ld_valid, ld_addr, ld_hazard  load word-match against pending entries
//   mem_req, mem_ack              memory write handshake
//   mem_addr, mem_byteen, mem_wdata  head entry presented to memory
//   count, empty                  occupancy
module store_merge_buffer
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [OP_W-1:0]          st_op,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_misalign,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_hazard,
    output logic                     mem_req,
    input  logic                     mem_ack,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W/8-1:0]      mem_byteen,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = off_bits(DATA_W);
    localparam int WA_W  = word_bits(ADDR_W, DATA_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    drain_state_e      state, state_next;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, tail_ptr;
    logic [DEPTH-1:0]  ent_valid;
    logic [WA_W-1:0]   ent_addr [DEPTH];
    logic [BYTES-1:0]  ent_be   [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    logic [BYTES-1:0]  al_be;
    logic [DATA_W-1:0] al_data;
    logic              al_mis;
    logic [WA_W-1:0]   st_word, ld_word;
    logic              head_locked, merge_hit, accept, push, pop;
    logic [CNT_W-1:0]  count_next;
    logic [DEPTH-1:0]  ld_match;
    logic              unused_ld_off;

    store_lane_align #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_align (
        .op       (st_op),
        .addr     (st_addr),
        .data     (st_data),
        .byteen   (al_be),
        .wdata    (al_data),
        .misalign (al_mis)
    );

    assign st_word       = st_addr[ADDR_W-1:OFF_W];
    assign ld_word       = ld_addr[ADDR_W-1:OFF_W];
    assign unused_ld_off = ^ld_addr[OFF_W-1:0];
    assign tail_ptr      = wr_ptr - PTR_W'(1);
    assign st_misalign   = st_valid & al_mis;

    // The head is frozen while it is being offered to memory, so a store
    // to that word must open a new entry instead of merging.
    assign head_locked = (state == REQ);
    assign merge_hit   = (count != '0) && (st_word == ent_addr[tail_ptr])
                         && !(head_locked && (tail_ptr == rd_ptr));

    // Registered count only: a pop in this cycle does not free a slot.
    assign st_ready   = merge_hit | (count < CNT_W'(DEPTH));
    assign accept     = st_valid & st_ready & (st_op != ST_NONE) & ~al_mis;
    assign push       = accept & ~merge_hit;
    assign pop        = (state == REQ) & mem_ack;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (pop) begin
                rd_ptr            <= rd_ptr + PTR_W'(1);
                ent_valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr            <= wr_ptr + PTR_W'(1);
                ent_valid[wr_ptr] <= 1'b1;
            end
            count <= count_next;
        end
    end

    // Entry payload carries no reset; ent_valid/count decide what is live.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (merge_hit) begin
                ent_be[tail_ptr] <= ent_be[tail_ptr] | al_be;
                for (int b = 0; b < BYTES; b++) begin
                    if (al_be[b]) begin
                        ent_data[tail_ptr][8*b +: 8] <= al_data[8*b +: 8];
                    end
                end
            end else begin
                ent_addr[wr_ptr] <= st_word;
                ent_be[wr_ptr]   <= al_be;
                ent_data[wr_ptr] <= al_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) state_next = REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ack && (count_next == '0)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_addr   = mem_req ? {ent_addr[rd_ptr], {OFF_W{1'b0}}} : '0;
    assign mem_byteen = mem_req ? ent_be[rd_ptr]   : '0;
    assign mem_wdata  = mem_req ? ent_data[rd_ptr] : '0;
    assign empty      = (count == '0);

    always_comb begin
        ld_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_match[i] = ent_valid[i] && (ent_addr[i] == ld_word);
        end
    end

    assign ld_hazard = ld_valid & (|ld_match);

endmodule

// File: tb/tb_store_merge_buffer.sv
// Directed bench for store_merge_buffer: a 32-bit instance covers alignment,
// misalignment, merging, full/merge readiness, hazards and reset; a 64-bit
// instance covers doubleword stores.
module tb_store_merge_buffer;

    logic        clk;
    logic        reset;

    logic        st_valid, st_ready, st_misalign;
    logic [2:0]  st_op;
    logic [31:0] st_addr, st_data;
    logic        ld_valid, ld_hazard;
    logic [31:0] ld_addr;
    logic        mem_req, mem_ack;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_byteen;
    logic [2:0]  count;
    logic        empty;

    logic        st_valid64, st_ready64, st_misalign64;
    logic [2:0]  st_op64;
    logic [31:0] st_addr64;
    logic [63:0] st_data64;
    logic        ld_valid64, ld_hazard64;
    logic [31:0] ld_addr64;
    logic        mem_req64, mem_ack64;
    logic [31:0] mem_addr64;
    logic [63:0] mem_wdata64;
    logic [7:0]  mem_byteen64;
    logic [2:0]  count64;
    logic        empty64;

    int checks = 0;
    int errors = 0;

    store_merge_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data), .st_misalign(st_misalign),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
        .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
        .count(count), .empty(empty)
    );

    store_merge_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut64 (
        .clk(clk), .reset(reset),
        .st_valid(st_valid64), .st_ready(st_ready64), .st_op(st_op64),
        .st_addr(st_addr64), .st_data(st_data64), .st_misalign(st_misalign64),
        .ld_valid(ld_valid64), .ld_addr(ld_addr64), .ld_hazard(ld_hazard64),
        .mem_req(mem_req64), .mem_ack(mem_ack64), .mem_addr(mem_addr64),
        .mem_byteen(mem_byteen64), .mem_wdata(mem_wdata64),
        .count(count64), .empty(empty64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_st(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = addr;
        st_data  = data;
    endtask

    initial begin
        reset = 1'b1;
        st_valid = 1'b0; st_op = 3'd0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; mem_ack = 1'b0;
        st_valid64 = 1'b0; st_op64 = 3'd0; st_addr64 = '0; st_data64 = '0;
        ld_valid64 = 1'b0; ld_addr64 = '0; mem_ack64 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        ld_valid = 1'b1;
        #1;
        chk("rst_mem_req",  64'(mem_req),    64'h0);
        chk("rst_count",    64'(count),      64'h0);
        chk("rst_empty",    64'(empty),      64'h1);
        chk("rst_mem_addr", 64'(mem_addr),   64'h0);
        chk("rst_byteen",   64'(mem_byteen), 64'h0);
        chk("rst_wdata",    64'(mem_wdata),  64'h0);
        chk("rst_hazard",   64'(ld_hazard),  64'h0);
        ld_valid = 1'b0;

        // sb @0x1003, acked on the first request cycle
        drive_st(3'd1, 32'h1003, 32'h0000_00AB);
        #1;
        chk("t1_ready",    64'(st_ready),    64'h1);
        chk("t1_misalign", 64'(st_misalign), 64'h0);
        tick();
        st_valid = 1'b0;
        chk("t1_count1",   64'(count),   64'h1);
        tick();
        chk("t1_req",      64'(mem_req),    64'h1);
        chk("t1_addr",     64'(mem_addr),   64'h1000);
        chk("t1_byteen",   64'(mem_byteen), 64'h8);
        chk("t1_wdata",    64'(mem_wdata),  64'hAB00_0000);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("t1_count0",   64'(count),   64'h0);
        chk("t1_req_low",  64'(mem_req), 64'h0);

        // misaligned half and word
        drive_st(3'd2, 32'h2001, 32'h0000_1234);
        #1;
        chk("t2_sh_mis",   64'(st_misalign), 64'h1);
        tick();
        drive_st(3'd3, 32'h2002, 32'h5566_7788);
        #1;
        chk("t2_sw_mis",   64'(st_misalign), 64'h1);
        tick();
        st_valid = 1'b0;
        #1;
        chk("t2_count",    64'(count),   64'h0);
        chk("t2_req",      64'(mem_req), 64'h0);

        // no merge into the locked head; merge into the second entry
        drive_st(3'd1, 32'h3000, 32'h11);
        tick();
        st_valid = 1'b0;
        tick();
        drive_st(3'd1, 32'h3001, 32'h22);
        #1;
        chk("t3_locked",   64'(mem_req), 64'h1);
        tick();
        drive_st(3'd1, 32'h3002, 32'h33);
        tick();
        st_valid = 1'b0;
        #1;
        chk("t3_count2",   64'(count),      64'h2);
        chk("t3_head_be",  64'(mem_byteen), 64'h1);
        chk("t3_head_wd",  64'(mem_wdata),  64'h0000_0011);
        mem_ack = 1'b1;
        tick();
        chk("t3_count1",   64'(count),      64'h1);
        chk("t3_e2_addr",  64'(mem_addr),   64'h3000);
        chk("t3_e2_be",    64'(mem_byteen), 64'h6);
        chk("t3_e2_wd",    64'(mem_wdata),  64'h0033_2200);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("t3_empty",    64'(empty),   64'h1);
        chk("t3_idle",     64'(mem_req), 64'h0);

        // fill to DEPTH, then a merge to the tail word is still accepted
        drive_st(3'd3, 32'h0100, 32'h1); tick();
        drive_st(3'd3, 32'h0104, 32'h2); tick();
        drive_st(3'd3, 32'h0108, 32'h3); tick();
        drive_st(3'd3, 32'h010C, 32'h4); tick();
        drive_st(3'd3, 32'h0200, 32'h5);
        #1;
        chk("t4_count4",   64'(count),    64'h4);
        chk("t4_full_rdy", 64'(st_ready), 64'h0);
        drive_st(3'd1, 32'h010D, 32'h55);
        #1;
        chk("t4_merge_rdy", 64'(st_ready), 64'h1);
        tick();
        st_valid = 1'b0;
        chk("t4_count_m",  64'(count),    64'h4);
        chk("t4_head",     64'(mem_addr), 64'h0100);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("t4_count3",   64'(count),    64'h3);
        chk("t4_head2",    64'(mem_addr), 64'h0104);
        mem_ack = 1'b1;
        tick();
        tick();
        chk("t4_tail_addr", 64'(mem_addr),   64'h010C);
        chk("t4_tail_be",   64'(mem_byteen), 64'hF);
        chk("t4_tail_wd",   64'(mem_wdata),  64'h0000_5504);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("t4_empty",    64'(empty), 64'h1);

        // load hazard against pending and locked entries
        drive_st(3'd3, 32'h4000, 32'hDEAD_BEEF);
        tick();
        st_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 32'h4002;
        #1;
        chk("t5_haz_hit",  64'(ld_hazard), 64'h1);
        ld_addr  = 32'h4004;
        #1;
        chk("t5_haz_miss", 64'(ld_hazard), 64'h0);
        tick();
        ld_addr  = 32'h4002;
        #1;
        chk("t5_haz_lock", 64'(ld_hazard), 64'h1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("t5_haz_done", 64'(ld_hazard), 64'h0);
        ld_valid = 1'b0;

        // reset while draining three entries
        drive_st(3'd3, 32'h0600, 32'h6); tick();
        drive_st(3'd3, 32'h0604, 32'h7); tick();
        drive_st(3'd3, 32'h0608, 32'h8); tick();
        st_valid = 1'b0;
        #1;
        chk("t6_req_pre",  64'(mem_req), 64'h1);
        chk("t6_count3",   64'(count),   64'h3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("t6_req_rst",  64'(mem_req), 64'h0);
        chk("t6_count_rst", 64'(count),  64'h0);
        chk("t6_empty_rst", 64'(empty),  64'h1);
        drive_st(3'd3, 32'h5000, 32'hCAFE_F00D);
        tick();
        st_valid = 1'b0;
        tick();
        chk("t6_addr",     64'(mem_addr),   64'h5000);
        chk("t6_be",       64'(mem_byteen), 64'hF);
        chk("t6_wd",       64'(mem_wdata),  64'hCAFE_F00D);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("t6_empty",    64'(empty), 64'h1);

        // doubleword is illegal on a 32-bit buffer
        drive_st(3'd4, 32'h5008, 32'h1);
        #1;
        chk("t6_sd32_mis", 64'(st_misalign), 64'h1);
        tick();
        st_valid = 1'b0;
        #1;
        chk("t6_sd32_cnt", 64'(count), 64'h0);

        // 64-bit instance: sd then sw to the upper half of the next word
        st_valid64 = 1'b1; st_op64 = 3'd4; st_addr64 = 32'h5008;
        st_data64  = 64'h0123_4567_89AB_CDEF;
        #1;
        chk("d64_sd_mis",  64'(st_misalign64), 64'h0);
        tick();
        st_op64 = 3'd3; st_addr64 = 32'h5014; st_data64 = 64'h0000_0000_89AB_CDEF;
        tick();
        st_valid64 = 1'b0;
        #1;
        chk("d64_count2",  64'(count64),      64'h2);
        chk("d64_sd_addr", 64'(mem_addr64),   64'h5008);
        chk("d64_sd_be",   64'(mem_byteen64), 64'hFF);
        chk("d64_sd_wd",   mem_wdata64,       64'h0123_4567_89AB_CDEF);
        mem_ack64 = 1'b1;
        tick();
        chk("d64_sw_addr", 64'(mem_addr64),   64'h5010);
        chk("d64_sw_be",   64'(mem_byteen64), 64'hF0);
        chk("d64_sw_wd",   mem_wdata64,       64'h89AB_CDEF_0000_0000);
        tick();
        mem_ack64 = 1'b0;
        #1;
        chk("d64_empty",   64'(empty64), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
